idex_pipe_reg: RTL and testbench
================================

Name: idex_pipe_reg

Overview:
- ID/EX pipeline register for the 16-bit five-stage core.
- Sits between decode and execute. It supplies the forwarding unit's ID/EX-side inputs (instr, ALUSrc2, Set, DMemWrite, Lbi, PCImm) and execute's operands.
- Implements three behaviours:
  - hold on a global memory stall;
  - bubble insertion on a load-use stall (exex_stall);
  - squash on a taken branch/jump.
- Keeps held operands coherent with writeback and counts lost cycles for performance debug.

Parameters:
- NOP_INSTR, 16'h0800, encoding written into instr_ex on a bubble or squash.
- CNT_W, 16, width of the saturating bubble and flush counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_id  in  16  decoded instruction.
- pc_inc_id  in  16  PC+2 of the decoded instruction.
- rs_data_id, rt_data_id  in  16 each  register-file read data.
- imm_id  in  16  extended immediate.
- ctrl_id  in  10  {RegDst[1:0], RegWrite, MemtoReg, DMemEn, DMemWrite, ALUSrc2, Set, Lbi, PCImm}.
- valid_id  in  1  decode slot holds a real instruction.
- stall_mem  in  1  cache or memory busy; the whole pipe freezes.
- exex_stall  in  1  load-use hazard from the forwarding unit.
- flush  in  1  taken branch/jump resolved in EX.
- wb_en  in  1  writeback register write this cycle.
- wb_reg  in  3  writeback destination register.
- wb_data  in  16  writeback data.
- instr_ex, pc_inc_ex, rs_data_ex, rt_data_ex, imm_ex  out  16 each  registered copies of the decode fields.
- ctrl_ex  out  10  registered controls, same packing as ctrl_id.
- valid_ex  out  1  EX slot holds a real instruction.
- bubble_cnt  out  CNT_W  count of cycles lost to load-use bubbles.
- flush_cnt  out  CNT_W  count of instructions squashed.

Behaviour:
- Reset (asynchronous, on the rising edge of rst):
  - instr_ex = NOP_INSTR;
  - ctrl_ex = 0, valid_ex = 0;
  - all data outputs = 0;
  - both counters = 0.
- One-cycle latency: ID values present at clock edge N appear on the outputs after edge N.
- Per-edge action, in priority order:
  1. stall_mem=1 → HOLD. All fields keep their values; flush and exex_stall are ignored this cycle. The EX stage is frozen, so the owner keeps flush asserted until stall_mem falls.
  2. flush=1 → SQUASH. Load a bubble: instr_ex=NOP_INSTR, ctrl_ex=0, valid_ex=0, data fields=0. flush_cnt increments when valid_id=1.
  3. exex_stall=1 → BUBBLE. Load the same bubble contents as SQUASH. bubble_cnt increments.
  4. Otherwise → LOAD all ID fields; valid_ex=valid_id.
- Bubble/squash contents:
  - RegWrite, DMemEn and DMemWrite are all 0, so a bubble never matches any forwarding comparison and never writes state.
  - NOP_INSTR makes the forwarding unit's nop decode true.
- Operand refresh, only in HOLD with valid_ex=1 and wb_en=1:
  - if wb_reg == instr_ex[10:8], rs_data_ex <= wb_data;
  - if wb_reg == instr_ex[7:5], rt_data_ex <= wb_data;
  - both may update on the same edge.
  - Without this, a held instruction would miss a writeback that retires during the freeze.
- Refresh is also permitted in LOAD: when wb_en=1 and wb_reg matches the incoming instr_id field, latch wb_data instead of the register-file data. This makes the register file's write-then-read bypass explicit.
- Counters saturate at all-ones with no wrap, and are cleared only by rst.
- Reset asserted mid-operation forces the reset state immediately. The first edge after reset deasserts performs LOAD (or another action, by priority).
- No handshakes beyond the priority above; every action completes on a single edge.

Decomposition:
- Shared package (pipe_pkg):
  - NOP_INSTR;
  - ctrl bit-index constants (CTRL_REGDST_HI..CTRL_PCIMM);
  - the field slices RS_FIELD [10:8] and RT_FIELD [7:5].
- The forwarding unit, decode and this block all use these definitions.
- Natural sub-module: sat_counter (parameterised width, inc and clear) instantiated twice for bubble_cnt and flush_cnt.
- Storage uses the codebase's standard per-bit dff with an asynchronous-reset variant.

Test Plan:
- Reset: assert rst mid-run with instr_ex=16'h4123 → outputs go immediately to instr_ex=16'h0800, ctrl_ex=0, valid_ex=0, counters=0.
- Normal flow: instr_id=16'hD9A4, rs_data_id=16'h0005 for one edge → instr_ex=16'hD9A4 and rs_data_ex=16'h0005 the following cycle.
- Load-use: exex_stall=1 for 1 cycle → instr_ex=16'h0800, RegWrite=0, bubble_cnt 0→1. Assert exex_stall with flush=1 on the same edge → flush_cnt increments instead and bubble_cnt is unchanged.
- Hold with refresh:
  - setup: instr_ex rs=r3, stall_mem=1 for 3 cycles;
  - stimulus: wb_en=1, wb_reg=3, wb_data=16'hBEEF on cycle 2;
  - required: rs_data_ex=16'hBEEF, other fields unchanged;
  - a flush during the hold has no effect.
- Saturation: with CNT_W=4, 20 consecutive exex_stall cycles → bubble_cnt holds at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, ctrl bit positions and the ID/EX register layout
package pipe_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int CTRL_REGDST_HI = 9;
  localparam int CTRL_REGDST_LO = 8;
  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_DMEMEN    = 5;
  localparam int CTRL_DMEMWRITE = 4;
  localparam int CTRL_ALUSRC2   = 3;
  localparam int CTRL_SET       = 2;
  localparam int CTRL_LBI       = 1;
  localparam int CTRL_PCIMM     = 0;
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [9:0]  ctrl;
    logic        valid;
  } idex_t;
  function automatic logic [2:0] rs_of(input logic [15:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction
  function automatic logic [2:0] rt_of(input logic [15:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction
endpackage

// File: rtl/dff_ar.sv
// dff_ar: per-bit flip-flop bank with asynchronous active-high reset to RST_VAL
module dff_ar #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    always_ff @(posedge clk or posedge rst)
      if (rst) q[i] <= RST_VAL[i];
      else q[i] <= d[i];
  end
endmodule

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear and async reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX register with memory-stall hold, load-use bubble, branch squash and writeback refresh
module idex_pipe_reg #(
  parameter logic [15:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_id,
  input  logic [15:0]      pc_inc_id,
  input  logic [15:0]      rs_data_id,
  input  logic [15:0]      rt_data_id,
  input  logic [15:0]      imm_id,
  input  logic [9:0]       ctrl_id,
  input  logic             valid_id,
  input  logic             stall_mem,
  input  logic             exex_stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [2:0]       wb_reg,
  input  logic [15:0]      wb_data,
  output logic [15:0]      instr_ex,
  output logic [15:0]      pc_inc_ex,
  output logic [15:0]      rs_data_ex,
  output logic [15:0]      rt_data_ex,
  output logic [15:0]      imm_ex,
  output logic [9:0]       ctrl_ex,
  output logic             valid_ex,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipe_pkg::*;
  localparam idex_t BUBBLE = idex_t'({NOP_INSTR, {($bits(idex_t) - 16){1'b0}}});
  idex_t cur, nxt;
  logic kill, refresh_ok;
  logic [15:0] ref_instr;
  assign kill = flush | exex_stall;
  // A held instruction refreshes against its own fields; a loading one against the incoming fields
  assign ref_instr  = stall_mem ? cur.instr : instr_id;
  assign refresh_ok = wb_en && (stall_mem ? cur.valid : !kill);
  always_comb begin
    nxt = stall_mem ? cur : kill ? BUBBLE :
          '{instr_id, pc_inc_id, rs_data_id, rt_data_id, imm_id, ctrl_id, valid_id};
    if (refresh_ok && wb_reg == rs_of(ref_instr)) nxt.rs_data = wb_data;
    if (refresh_ok && wb_reg == rt_of(ref_instr)) nxt.rt_data = wb_data;
  end
  dff_ar #(.W($bits(idex_t)), .RST_VAL(BUBBLE)) u_reg (
    .clk(clk), .rst(rst), .d(nxt), .q(cur)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(!stall_mem && !flush && exex_stall), .clr(1'b0), .q(bubble_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(!stall_mem && flush && valid_id), .clr(1'b0), .q(flush_cnt)
  );
  assign instr_ex   = cur.instr;
  assign pc_inc_ex  = cur.pc_inc;
  assign rs_data_ex = cur.rs_data;
  assign rt_data_ex = cur.rt_data;
  assign imm_ex     = cur.imm;
  assign ctrl_ex    = cur.ctrl;
  assign valid_ex   = cur.valid;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: vector table, hand sequences and randomized run against a behavioural model
module tb_idex_pipe_reg;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic [15:0] instr_id = 0, pc_inc_id = 0, rs_data_id = 0, rt_data_id = 0, imm_id = 0, wb_data = 0;
  logic [9:0] ctrl_id = 0;
  logic valid_id = 0, stall_mem = 0, exex_stall = 0, flush = 0, wb_en = 0;
  logic [2:0] wb_reg = 0;
  logic [15:0] instr_ex, pc_inc_ex, rs_data_ex, rt_data_ex, imm_ex;
  logic [9:0] ctrl_ex;
  logic valid_ex;
  logic [CW-1:0] bubble_cnt, flush_cnt;
  int tests = 0, fails = 0;

  idex_pipe_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .pc_inc_id(pc_inc_id), .rs_data_id(rs_data_id),
    .rt_data_id(rt_data_id), .imm_id(imm_id), .ctrl_id(ctrl_id), .valid_id(valid_id),
    .stall_mem(stall_mem), .exex_stall(exex_stall), .flush(flush), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .instr_ex(instr_ex), .pc_inc_ex(pc_inc_ex),
    .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex), .imm_ex(imm_ex), .ctrl_ex(ctrl_ex),
    .valid_ex(valid_ex), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [15:0] m_instr, m_pc, m_rs, m_rt, m_imm;
  logic [9:0] m_ctrl;
  logic m_valid;
  int m_b, m_f;

  task automatic model_reset();
    m_instr = 16'h0800; m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_ctrl = 0; m_valid = 0;
    m_b = 0; m_f = 0;
  endtask

  task automatic model_edge();
    if (stall_mem) begin
      if (m_valid && wb_en && wb_reg == m_instr[10:8]) m_rs = wb_data;
      if (m_valid && wb_en && wb_reg == m_instr[7:5]) m_rt = wb_data;
    end else if (flush || exex_stall) begin
      if (flush) m_f = (valid_id && m_f < SAT) ? m_f + 1 : m_f;
      else m_b = (m_b < SAT) ? m_b + 1 : m_b;
      m_instr = 16'h0800; m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_ctrl = 0; m_valid = 0;
    end else begin
      m_instr = instr_id; m_pc = pc_inc_id; m_imm = imm_id; m_ctrl = ctrl_id; m_valid = valid_id;
      m_rs = (wb_en && wb_reg == instr_id[10:8]) ? wb_data : rs_data_id;
      m_rt = (wb_en && wb_reg == instr_id[7:5]) ? wb_data : rt_data_id;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("rnd_instr", 32'(instr_ex), 32'(m_instr));
    chk("rnd_pc", 32'(pc_inc_ex), 32'(m_pc));
    chk("rnd_rs", 32'(rs_data_ex), 32'(m_rs));
    chk("rnd_rt", 32'(rt_data_ex), 32'(m_rt));
    chk("rnd_imm", 32'(imm_ex), 32'(m_imm));
    chk("rnd_ctrl", 32'(ctrl_ex), 32'(m_ctrl));
    chk("rnd_valid", 32'(valid_ex), 32'(m_valid));
    chk("rnd_bcnt", 32'(bubble_cnt), 32'(m_b));
    chk("rnd_fcnt", 32'(flush_cnt), 32'(m_f));
  endtask

  typedef struct {
    logic stall, fl, ex, vld, wen;
    logic [15:0] instr, rs;
    logic [2:0] wreg;
    logic [15:0] wdata;
    logic [15:0] e_instr, e_rs;
    logic e_valid;
    logic [3:0] e_b, e_f;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{0,0,0,1,0, 16'hD9A4, 16'h0005, 3'd0, 16'h0000, 16'hD9A4, 16'h0005, 1, 0, 0};
    vt[1] = '{0,0,1,1,0, 16'h1234, 16'h0011, 3'd0, 16'h0000, 16'h0800, 16'h0000, 0, 1, 0};
    vt[2] = '{0,1,1,1,0, 16'h1234, 16'h0011, 3'd0, 16'h0000, 16'h0800, 16'h0000, 0, 1, 1};
    vt[3] = '{0,0,0,1,1, 16'h6160, 16'h1111, 3'd1, 16'hABCD, 16'h6160, 16'hABCD, 1, 1, 1};
    vt[4] = '{1,1,0,1,0, 16'hFFFF, 16'h2222, 3'd1, 16'h9999, 16'h6160, 16'hABCD, 1, 1, 1};
    vt[5] = '{1,0,0,1,1, 16'hFFFF, 16'h2222, 3'd1, 16'h5555, 16'h6160, 16'h5555, 1, 1, 1};
    vt[6] = '{0,1,0,0,0, 16'h7777, 16'h3333, 3'd0, 16'h0000, 16'h0800, 16'h0000, 0, 1, 1};
    vt[7] = '{0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1};
    model_reset();
    #12;
    chk("rst_instr", 32'(instr_ex), 32'h0800);
    chk("rst_ctrl", 32'(ctrl_ex), 0);
    chk("rst_valid", 32'(valid_ex), 0);
    chk("rst_rs", 32'(rs_data_ex), 0);
    @(negedge clk) rst = 0;
    pc_inc_id = 16'h0102; rt_data_id = 16'h0007; imm_id = 16'h0009; ctrl_id = 10'h3FF;
    for (int i = 0; i < 8; i++) begin
      stall_mem = vt[i].stall; flush = vt[i].fl; exex_stall = vt[i].ex; valid_id = vt[i].vld;
      wb_en = vt[i].wen; instr_id = vt[i].instr; rs_data_id = vt[i].rs;
      wb_reg = vt[i].wreg; wb_data = vt[i].wdata;
      tick();
      chk($sformatf("vec%0d_instr", i), 32'(instr_ex), 32'(vt[i].e_instr));
      chk($sformatf("vec%0d_rs", i), 32'(rs_data_ex), 32'(vt[i].e_rs));
      chk($sformatf("vec%0d_valid", i), 32'(valid_ex), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_bcnt", i), 32'(bubble_cnt), 32'(vt[i].e_b));
      chk($sformatf("vec%0d_fcnt", i), 32'(flush_cnt), 32'(vt[i].e_f));
      if (i == 1) chk("bubble_regwrite", 32'(ctrl_ex[7]), 0);
    end
    // hold with writeback refresh; a flush during the hold is ignored
    stall_mem = 0; flush = 0; exex_stall = 0; wb_en = 0;
    instr_id = 16'h4300; rs_data_id = 16'h0001; rt_data_id = 16'h0002; valid_id = 1;
    tick();
    stall_mem = 1; instr_id = 16'h1111; rs_data_id = 16'hDEAD;
    tick();
    wb_en = 1; wb_reg = 3'd3; wb_data = 16'hBEEF;
    tick();
    wb_en = 0; flush = 1;
    tick();
    chk("hold_rs", 32'(rs_data_ex), 32'hBEEF);
    chk("hold_rt", 32'(rt_data_ex), 32'h0002);
    chk("hold_instr", 32'(instr_ex), 32'h4300);
    chk("hold_valid", 32'(valid_ex), 1);
    chk("hold_fcnt", 32'(flush_cnt), 1);
    // bubble counter saturation
    stall_mem = 0; flush = 0; exex_stall = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_bcnt", 32'(bubble_cnt), 32'hF);
    // asynchronous reset mid-run
    exex_stall = 0; instr_id = 16'h4123; ctrl_id = 10'h2A5;
    tick();
    chk("pre_rst_instr", 32'(instr_ex), 32'h4123);
    rst = 1;
    #1;
    chk("mid_rst_instr", 32'(instr_ex), 32'h0800);
    chk("mid_rst_ctrl", 32'(ctrl_ex), 0);
    chk("mid_rst_valid", 32'(valid_ex), 0);
    chk("mid_rst_bcnt", 32'(bubble_cnt), 0);
    chk("mid_rst_fcnt", 32'(flush_cnt), 0);
    @(negedge clk) rst = 0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      stall_mem = ($urandom_range(3) == 0); flush = ($urandom_range(6) == 0);
      exex_stall = ($urandom_range(4) == 0); valid_id = $urandom_range(1);
      wb_en = $urandom_range(1); wb_reg = 3'($urandom_range(7)); wb_data = 16'($urandom);
      instr_id = 16'($urandom); pc_inc_id = 16'($urandom); rs_data_id = 16'($urandom);
      rt_data_id = 16'($urandom); imm_id = 16'($urandom); ctrl_id = 10'($urandom);
      tick();
      chk_model();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
